// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: walks a word-indexed pc over a combinational program memory,
// decodes each word and issues it downstream over a valid/ready handshake.
module instr_fetch_decode #(
  parameter int MEM_DEPTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          start_pc,
  output logic [31:0]          pc,
  input  logic [31:0]          instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           opcode,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [5:0]           funct,
  output logic [31:0]          imm,
  output logic [2:0]           op_kind,
  output logic                 halted,
  output logic                 error,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  localparam logic [2:0] K_ADD     = 3'd0;
  localparam logic [2:0] K_SUB     = 3'd1;
  localparam logic [2:0] K_MUL     = 3'd2;
  localparam logic [2:0] K_SLL     = 3'd3;
  localparam logic [2:0] K_ADDI    = 3'd4;
  localparam logic [2:0] K_LW      = 3'd5;
  localparam logic [2:0] K_SW      = 3'd6;
  localparam logic [2:0] K_ILLEGAL = 3'd7;

  state_t                r_state;
  logic [31:0]           r_pc;
  logic                  r_valid;
  logic [31:0]           r_word;
  logic [2:0]            r_kind;
  logic                  r_halted;
  logic                  r_error;
  logic [CNT_WIDTH-1:0]  r_count;

  state_t                w_state_next;
  logic [31:0]           w_pc_next;
  logic                  w_valid_next;
  logic [31:0]           w_word_next;
  logic [2:0]            w_kind_next;
  logic                  w_halted_next;
  logic                  w_error_next;
  logic [CNT_WIDTH-1:0]  w_count_next;

  logic                  w_load;
  logic                  w_in_range;
  logic [2:0]            w_kind;

  assign w_load     = !r_valid || out_ready;
  assign w_in_range = r_pc < 32'(MEM_DEPTH);

  // Classification of the word currently on the memory bus; the all-zero HALT
  // word never reaches the payload, so funct 000000 here always means SLL.
  always_comb begin
    w_kind = K_ILLEGAL;
    case (instruction[31:26])
      6'b000000: begin
        case (instruction[5:0])
          6'b100000: w_kind = K_ADD;
          6'b100010: w_kind = K_SUB;
          6'b000010: w_kind = K_MUL;
          6'b000000: w_kind = K_SLL;
          default:   w_kind = K_ILLEGAL;
        endcase
      end
      6'b001000: w_kind = K_ADDI;
      6'b100011: w_kind = K_LW;
      6'b101011: w_kind = K_SW;
      default:   w_kind = K_ILLEGAL;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_valid_next  = r_valid;
    w_word_next   = r_word;
    w_kind_next   = r_kind;
    w_halted_next = r_halted;
    w_error_next  = r_error;
    w_count_next  = r_count;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_pc_next     = start_pc;
          w_valid_next  = 1'b0;
          w_halted_next = 1'b0;
          w_error_next  = 1'b0;
          w_count_next  = '0;
          w_state_next  = S_RUN;
        end else if (r_valid && out_ready) begin
          w_valid_next = 1'b0;
        end
      end
      S_RUN: begin
        if (w_load) begin
          if (!w_in_range) begin
            w_error_next  = 1'b1;
            w_halted_next = 1'b1;
            w_valid_next  = 1'b0;
            w_state_next  = S_HALTED;
          end else if (instruction == 32'd0) begin
            w_halted_next = 1'b1;
            w_valid_next  = 1'b0;
            w_state_next  = S_HALTED;
          end else begin
            w_word_next  = instruction;
            w_kind_next  = w_kind;
            w_valid_next = 1'b1;
            w_pc_next    = r_pc + 32'd1;
            if (r_count != {CNT_WIDTH{1'b1}}) begin
              w_count_next = r_count + 1'b1;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_word   <= '0;
      r_kind   <= '0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_valid  <= w_valid_next;
      r_word   <= w_word_next;
      r_kind   <= w_kind_next;
      r_halted <= w_halted_next;
      r_error  <= w_error_next;
      r_count  <= w_count_next;
    end
  end

  assign pc          = r_pc;
  assign out_valid   = r_valid;
  assign opcode      = r_word[31:26];
  assign rs          = r_word[25:21];
  assign rt          = r_word[20:16];
  assign rd          = r_word[15:11];
  assign shamt       = r_word[10:6];
  assign funct       = r_word[5:0];
  assign imm         = {{16{r_word[15]}}, r_word[15:0]};
  assign op_kind     = r_kind;
  assign halted      = r_halted;
  assign error       = r_error;
  assign busy        = (r_state == S_RUN);
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: a program-level model predicts the issued
// stream and final status; a negedge monitor checks every presented instruction.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_pc = '0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm;
  logic [2:0]  op_kind;
  logic        halted, error, busy;
  logic [15:0] instr_count;

  instr_fetch_decode #(.MEM_DEPTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .pc(pc),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .op_kind(op_kind), .halted(halted), .error(error), .busy(busy),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  assign instruction = (pc < 32) ? mem[pc[4:0]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [2:0]  kind;
  } item_t;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    pops    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] k);
    return {op, s, t, k};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'd0, s, t, d, sh, fn};
  endfunction

  // Operation class straight from the instruction-set table.
  function automatic logic [2:0] ref_kind(input logic [31:0] w);
    if (w[31:26] == 6'h00) begin
      if (w[5:0] == 6'h20) return 3'd0;
      if (w[5:0] == 6'h22) return 3'd1;
      if (w[5:0] == 6'h02) return 3'd2;
      if (w[5:0] == 6'h00) return 3'd3;
      return 3'd7;
    end
    if (w[31:26] == 6'h08) return 3'd4;
    if (w[31:26] == 6'h23) return 3'd5;
    if (w[31:26] == 6'h2B) return 3'd6;
    return 3'd7;
  endfunction

  // Walk the program from spc: every nonzero in-range word is issued in order.
  task automatic predict(input int unsigned spc, output int unsigned end_pc,
                         output logic end_err, output int unsigned cnt);
    int unsigned p = spc;
    item_t it;
    cnt = 0;
    while (p < 32 && mem[p] != 0) begin
      it.addr = p;
      it.word = mem[p];
      it.kind = ref_kind(mem[p]);
      exp_q.push_back(it);
      p++;
      cnt++;
    end
    end_pc  = p;
    end_err = (p >= 32);
    if (cnt > 65535) cnt = 65535;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {96'd0, pc}, 128'd0);
      end else begin
        check("payload", {opcode, rs, rt, rd, shamt, funct, imm, op_kind},
              {exp_q[0].word, {{16{exp_q[0].word[15]}}, exp_q[0].word[15:0]}, exp_q[0].kind});
        check("pc_after_issue", pc, exp_q[0].addr + 32'd1);
        if (out_ready) begin
          $display("[TB] issue addr=%0d word=%08h kind=%0d", exp_q[0].addr, exp_q[0].word, exp_q[0].kind);
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  // mode 0: ready always, 1: random ready, 2: 3-cycle stall at 2nd issue, 3: start pulse mid-run
  task automatic run_prog(input int unsigned spc, input int mode);
    int unsigned ep, ec;
    logic ee;
    int stalled = 0;
    logic done = 1'b0;
    predict(spc, ep, ee, ec);
    pops = 0;
    out_ready = 1'b1;
    start_pc = spc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_pc_load", pc, spc);
    check("busy_in_run", busy, 1'b1);
    check("no_valid_at_start", out_valid, 1'b0);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (pops >= 1 && stalled < 3) begin
            out_ready = 1'b0;
            stalled++;
          end else begin
            out_ready = 1'b1;
          end
        end
        3: begin
          start    = (c == 3);
          start_pc = (c == 3) ? 32'd3 : spc;
        end
        default: out_ready = 1'b1;
      endcase
      if (halted && !out_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("finished_in_budget", done, 1'b1);
    check("halted_end", halted, 1'b1);
    check("error_end", error, ee);
    check("pc_end", pc, ep);
    check("count_end", instr_count, ec[15:0]);
    check("busy_end", busy, 1'b0);
    check("issues_missing", exp_q.size(), 0);
    $display("[TB] run start_pc=%0d mode=%0d pc=%0d count=%0d error=%0d", spc, mode, pc, instr_count, error);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {pc, out_valid, opcode, rs, rt, rd, shamt, funct, imm, op_kind,
                 halted, error, busy, instr_count}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned ep, ec;
    logic ee;
    logic done;
    mem[0]  = i_type(6'h08, 5'd0, 5'd8, 16'd4);
    mem[1]  = i_type(6'h08, 5'd0, 5'd9, 16'd1);
    mem[2]  = i_type(6'h08, 5'd0, 5'd10, 16'd2);
    mem[3]  = i_type(6'h08, 5'd0, 5'd11, 16'd3);
    mem[4]  = i_type(6'h2B, 5'd29, 5'd8, 16'd0);
    mem[5]  = i_type(6'h2B, 5'd29, 5'd9, 16'd4);
    mem[6]  = i_type(6'h2B, 5'd29, 5'd10, 16'hFFFC);
    mem[7]  = 32'd0;
    mem[8]  = i_type(6'h08, 5'd0, 5'd8, 16'd7);
    mem[9]  = i_type(6'h08, 5'd0, 5'd9, 16'd15);
    mem[10] = i_type(6'h2B, 5'd29, 5'd8, 16'd0);
    mem[11] = r_type(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
    mem[12] = r_type(5'd10, 5'd8, 5'd11, 5'd0, 6'h22);
    mem[13] = r_type(5'd8, 5'd9, 5'd12, 5'd0, 6'h02);
    mem[14] = i_type(6'h08, 5'd12, 5'd17, 16'd3);
    mem[15] = i_type(6'h23, 5'd8, 5'd18, 16'hFFFC);
    mem[16] = r_type(5'd11, 5'd12, 5'd13, 5'd0, 6'h22);
    mem[17] = r_type(5'd17, 5'd0, 5'd18, 5'd2, 6'h00);
    mem[18] = i_type(6'h2B, 5'd29, 5'd18, 16'd8);
    mem[19] = 32'd0;
    mem[20] = i_type(6'h04, 5'd1, 5'd2, 16'd5);
    mem[21] = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    mem[22] = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h01);
    mem[23] = 32'd0;
    for (int i = 24; i < 32; i++) mem[i] = 32'h2000_0001 + i;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_not_busy", busy, 1'b0);

    run_prog(0, 0);
    run_prog(8, 0);
    run_prog(8, 2);
    run_prog(32, 0);
    run_prog(0, 0);
    run_prog(20, 0);
    run_prog(24, 0);
    run_prog(8, 3);
    run_prog(8, 1);

    // Abort mid-run: reset must clear everything as soon as it is asserted.
    predict(0, ep, ec, ec);
    ee = 1'b0;
    pops = 0;
    start_pc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (pops >= 3) begin
        done = 1'b1;
        break;
      end
    end
    check("reached_3_issues", done, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_mid_run");
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 1'b0);
    run_prog(0, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 24; i < 32; i++) begin
        case ($urandom_range(0, 7))
          0: mem[i] = 32'd0;
          1: mem[i] = r_type(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'h20);
          2: mem[i] = i_type(6'h23, 5'($urandom), 5'($urandom), 16'($urandom));
          3: mem[i] = i_type(6'h08, 5'($urandom), 5'($urandom), 16'($urandom));
          default: mem[i] = $urandom | 32'h0000_0100;
        endcase
      end
      run_prog(24 + $urandom_range(0, 7), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
